// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the decode stage, the execute stage and the writeback register.
// Upstream offers op/a/b with in_valid; downstream takes result/zero with out_ready.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_stage.sv
// RV32I execute stage: single-cycle logic/arith/compare ops and a 1-bit-per-cycle
// iterative shifter, with one registered result held until the consumer takes it.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_stage_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             right_q, right_d;
  logic             arith_q, arith_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] work_shifted;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             accept;

  assign shamt    = bus.b[SW-1:0];
  assign is_shift = (bus.op == 4'b0001) || (bus.op == 4'b0101) || (bus.op == 4'b1101);
  assign accept   = (state_q == IDLE) && bus.in_valid;

  // Single-cycle ops; shift codes fall to default because they take the iterative path.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      4'b0000: alu_res = bus.a + bus.b;
      4'b1000: alu_res = bus.a - bus.b;
      4'b0010: alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      4'b0011: alu_res = WIDTH'(bus.a < bus.b);
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0110: alu_res = bus.a | bus.b;
      4'b0111: alu_res = bus.a & bus.b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    if (!right_q) begin
      work_shifted = {work_q[WIDTH-2:0], 1'b0};
    end else begin
      work_shifted = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (is_shift && (shamt != '0)) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SW'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the final shift step writes the result directly.
  always_comb begin
    result_d = result_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    right_d  = right_q;
    arith_d  = arith_q;
    if (accept) begin
      right_d = bus.op[2];
      arith_d = bus.op[3];
      if (!is_shift) begin
        result_d = alu_res;
      end else if (shamt == '0) begin
        result_d = bus.a;
      end else begin
        work_d = bus.a;
        cnt_d  = shamt;
      end
    end else if (state_q == SHIFT) begin
      work_d = work_shifted;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == SW'(1)) result_d = work_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      arith_q  <= arith_d;
    end
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
    bus.zero      = (result_q == '0);
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases plus randomized ops against an
// arithmetic reference model of the RV32I semantics and latency rules.
module tb_alu_exec_stage;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return 32'(sa >>> sh);
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    bit shift_op;
    shift_op = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101);
    return (shift_op && (b % 32) != 0) ? int'(b % 32) + 1 : 1;
  endfunction

  // One full transaction: accept, wait for completion, optional stall, release.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int stall);
    int lat;
    check({name, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.op       = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".result"}, bus.result, exp_res);
    check({name, ".zero"}, 32'(bus.zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
    check({name, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, ".hold_result"}, bus.result, exp_res);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, ".released"}, 32'(bus.out_valid), 32'd0);
    $display("txn %s op=%b a=%h b=%h result=%h lat=%0d", name, op, a, b, exp_res, lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 4'd0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0);
    run_op("or",  4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 0);
    run_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);
    run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run_op("sub", 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
    run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
    run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run_op("sra31", 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 0);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 0);
    run_op("sll_sh0", 4'b0001, 32'd1, 32'h20, 32'd1, 1, 0);
    run_op("illegal", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 0);

    // Back-pressure with a competing request that must be ignored.
    bus.op = 4'b0100; bus.a = 32'h1234_5678; bus.b = 32'h0F0F_0F0F; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op = 4'b0000; bus.a = 32'd1; bus.b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.result", bus.result, 32'h1D3B_5977);
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp.idle_ready", 32'(bus.in_ready), 32'd1);
    check("bp.idle_valid", 32'(bus.out_valid), 32'd0);
    $display("txn backpressure op=0100 result=1d3b5977 stall=10");

    // Reset asserted partway through a long shift.
    bus.op = 4'b0001; bus.a = 32'd1; bus.b = 32'd20; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.result", bus.result, 32'd0);
    check("midrst.zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      check("midrst.no_done", 32'(bus.out_valid), 32'd0);
    end
    $display("txn midshift_reset op=0001 b=20");

    for (int t = 0; t < 1000; t++) begin
      r_op = 4'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_a = 32'hFFFF_FFFF;
        1: r_b = 32'h8000_0000;
        2: r_b = r_a;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", t), r_op, r_a, r_b, ref_result(r_op, r_a, r_b),
             ref_latency(r_op, r_b), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
